// File: rtl/mic_level_controller_pkg.sv
//==============================================================================
// Module   : mic_level_pkg
// Brief    : Shared widths, defaults and state encodings for the mic level path.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mic_level_pkg;

    localparam int MIC_W         = 12;
    localparam int LEVEL_W       = 4;
    localparam int WINDOW_CYCLES = 4001;
    localparam int CAL_WINDOWS   = 16;
    localparam int STEP          = 75;
    localparam int DEFAULT_BASE  = 2300;
    localparam int MAX_LEVEL     = 15;

    typedef enum logic {
        RUN = 1'b0,
        CAL = 1'b1
    } ctrl_state_e;

    typedef enum logic [1:0] {
        Q_IDLE = 2'd0,
        Q_SUB  = 2'd1,
        Q_DONE = 2'd2
    } quant_state_e;

endpackage

`default_nettype wire

// File: rtl/mic_level_controller_if.sv
//==============================================================================
// Module   : mic_level_controller_if
// Brief    : Sample/control inputs and level/status outputs of the controller.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mic_level_controller_if;
    import mic_level_pkg::*;

    logic [MIC_W-1:0]   mic_in;
    logic               cal_req;
    logic               hold_en;
    logic [LEVEL_W-1:0] level;
    logic               level_valid;
    logic [MIC_W-1:0]   peak;
    logic [MIC_W-1:0]   base;
    logic               busy;

    modport master (
        output mic_in, cal_req, hold_en,
        input  level, level_valid, peak, base, busy
    );

    modport slave (
        input  mic_in, cal_req, hold_en,
        output level, level_valid, peak, base, busy
    );

endinterface

`default_nettype wire

// File: rtl/mic_level_controller_quantizer.sv
//==============================================================================
// Module   : level_quantizer
// Brief    : Iterative subtract quantizer: level = min(MAX, (snap-base)/STEP+1).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module level_quantizer
    import mic_level_pkg::*;
#(
    parameter int STEP      = mic_level_pkg::STEP,
    parameter int MAX_LEVEL = mic_level_pkg::MAX_LEVEL
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                i_start,
    input  wire                i_abort,
    input  wire  [MIC_W-1:0]   i_snap,
    input  wire  [MIC_W-1:0]   i_base,
    output logic               o_done,
    output logic [LEVEL_W-1:0] o_lvl
);

    localparam logic [MIC_W-1:0]   c_STEP = MIC_W'(STEP);
    localparam logic [LEVEL_W-1:0] c_MAX  = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] c_ONE  = LEVEL_W'(1);

    quant_state_e       state_q, state_d;
    logic [MIC_W-1:0]   rem_q, rem_d;
    logic [LEVEL_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= Q_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        o_done  = 1'b0;
        if (i_abort) begin
            state_d = Q_IDLE;
        end else begin
            case (state_q)
                Q_IDLE: begin
                    if (i_start) begin
                        if (i_snap < i_base) begin
                            cnt_d   = '0;
                            state_d = Q_DONE;
                        end else begin
                            rem_d   = i_snap - i_base;
                            cnt_d   = c_ONE;
                            state_d = Q_SUB;
                        end
                    end
                end
                Q_SUB: begin
                    // Stop at saturation so huge peaks never take more than MAX_LEVEL steps.
                    if ((rem_q < c_STEP) || (cnt_q == c_MAX)) begin
                        state_d = Q_DONE;
                    end else begin
                        rem_d = rem_q - c_STEP;
                        cnt_d = cnt_q + c_ONE;
                    end
                end
                Q_DONE: begin
                    o_done  = 1'b1;
                    state_d = Q_IDLE;
                end
                default: state_d = Q_IDLE;
            endcase
        end
    end

    assign o_lvl = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mic_level_controller.sv
//==============================================================================
// Module   : mic_level_controller
// Brief    : Peak-hold windows, level quantization and ambient baseline calibration.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mic_level_controller
    import mic_level_pkg::*;
#(
    parameter int WINDOW_CYCLES = mic_level_pkg::WINDOW_CYCLES,
    parameter int CAL_WINDOWS   = mic_level_pkg::CAL_WINDOWS,
    parameter int STEP          = mic_level_pkg::STEP,
    parameter int DEFAULT_BASE  = mic_level_pkg::DEFAULT_BASE,
    parameter int MAX_LEVEL     = mic_level_pkg::MAX_LEVEL
) (
    input  wire                     clk,
    input  wire                     rst_n,
    mic_level_controller_if.slave   bus
);

    localparam int c_WIN_W     = $clog2(WINDOW_CYCLES);
    localparam int c_CAL_LOG2  = $clog2(CAL_WINDOWS);
    localparam int c_SUM_W     = MIC_W + c_CAL_LOG2;
    localparam logic [c_WIN_W-1:0]    c_WIN_LAST = c_WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [c_CAL_LOG2-1:0] c_CAL_LAST = c_CAL_LOG2'(CAL_WINDOWS - 1);
    localparam logic [MIC_W-1:0]      c_DEF_BASE = MIC_W'(DEFAULT_BASE);

    ctrl_state_e         state_q, state_d;
    logic [c_WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [MIC_W-1:0]      run_peak_q, run_peak_d;
    logic [MIC_W-1:0]      peak_q, peak_d;
    logic [MIC_W-1:0]      base_q, base_d;
    logic [c_SUM_W-1:0]    cal_sum_q, cal_sum_d;
    logic [c_CAL_LOG2-1:0] cal_cnt_q, cal_cnt_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic                  level_valid_q, level_valid_d;

    logic                  w_win_end;
    logic [MIC_W-1:0]      w_snap;
    logic [c_SUM_W-1:0]    w_sum_next;
    logic                  w_q_start;
    logic                  w_q_abort;
    logic                  w_q_done;
    logic [LEVEL_W-1:0]    w_q_lvl;

    assign w_win_end  = (win_cnt_q == c_WIN_LAST);
    assign w_snap     = (bus.mic_in > run_peak_q) ? bus.mic_in : run_peak_q;
    assign w_sum_next = cal_sum_q + c_SUM_W'(w_snap);

    level_quantizer #(
        .STEP      (STEP),
        .MAX_LEVEL (MAX_LEVEL)
    ) u_quant (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_q_start),
        .i_abort (w_q_abort),
        .i_snap  (w_snap),
        .i_base  (base_q),
        .o_done  (w_q_done),
        .o_lvl   (w_q_lvl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            win_cnt_q     <= '0;
            run_peak_q    <= '0;
            peak_q        <= '0;
            base_q        <= c_DEF_BASE;
            cal_sum_q     <= '0;
            cal_cnt_q     <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_cnt_q     <= win_cnt_d;
            run_peak_q    <= run_peak_d;
            peak_q        <= peak_d;
            base_q        <= base_d;
            cal_sum_q     <= cal_sum_d;
            cal_cnt_q     <= cal_cnt_d;
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        win_cnt_d     = w_win_end ? '0 : (win_cnt_q + c_WIN_W'(1));
        run_peak_d    = w_win_end ? '0 : w_snap;
        peak_d        = w_win_end ? w_snap : peak_q;
        base_d        = base_q;
        cal_sum_d     = cal_sum_q;
        cal_cnt_d     = cal_cnt_q;
        level_d       = level_q;
        level_valid_d = 1'b0;
        w_q_start     = 1'b0;
        w_q_abort     = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.cal_req) begin
                    // Calibration restarts the window; a coincident window end is discarded.
                    state_d    = CAL;
                    win_cnt_d  = '0;
                    run_peak_d = '0;
                    peak_d     = peak_q;
                    cal_sum_d  = '0;
                    cal_cnt_d  = '0;
                    w_q_abort  = 1'b1;
                end else begin
                    w_q_start = w_win_end;
                    if (w_q_done && !bus.hold_en) begin
                        level_d       = w_q_lvl;
                        level_valid_d = 1'b1;
                    end
                end
            end
            CAL: begin
                if (w_win_end) begin
                    cal_sum_d = w_sum_next;
                    cal_cnt_d = cal_cnt_q + c_CAL_LOG2'(1);
                    if (cal_cnt_q == c_CAL_LAST) begin
                        base_d  = w_sum_next[c_SUM_W-1:c_CAL_LOG2];
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.level       = level_q;
    assign bus.level_valid = level_valid_q;
    assign bus.peak        = peak_q;
    assign bus.base        = base_q;
    assign bus.busy        = (state_q == CAL);

endmodule

`default_nettype wire

// File: tb/tb_mic_level_controller.sv
//==============================================================================
// Module   : tb_mic_level_controller
// Brief    : Self-checking bench: window stimulus, reference model and strobe scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mic_level_controller;
    import mic_level_pkg::*;

    localparam int W    = 40;
    localparam int CALW = 16;
    localparam int CSH  = 4;

    typedef struct {
        int lvl;
        int pk;
    } exp_t;

    typedef struct {
        int mic;
        int lvl;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mic_level_controller_if bus();

    mic_level_controller #(
        .WINDOW_CYCLES (W),
        .CAL_WINDOWS   (CALW),
        .STEP          (75),
        .DEFAULT_BASE  (2300),
        .MAX_LEVEL     (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   strobes = 0;
    int   last_strobe = 0;
    int   prev_strobe = 0;

    int m_pos, m_run, m_base, m_cal, m_sum, m_cnt, m_level;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_level(input int snap, input int base);
        int l;
        if (snap < base) return 0;
        l = (snap - base) / 75 + 1;
        return (l > 15) ? 15 : l;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_run = 0; m_base = 2300; m_cal = 0;
        m_sum = 0; m_cnt = 0; m_level = 0;
        sbq.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.level_valid === 1'b1) begin
            strobes++;
            prev_strobe = last_strobe;
            last_strobe = cyc;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got level %0d, expected no strobe", bus.level);
            end else begin
                e = sbq.pop_front();
                check("strobe_level", int'(bus.level), e.lvl);
                check("strobe_peak", int'(bus.peak), e.pk);
            end
        end
    end

    // One sample slot; xl >= 0 overrides the model's expected level at a window end.
    task automatic step(input int val, input bit cal, input bit hold, input int xl);
        int snap, e;
        bit wend, take;
        bus.mic_in  = 12'(val);
        bus.cal_req = cal;
        bus.hold_en = hold;
        snap = (val > m_run) ? val : m_run;
        wend = (m_pos == W - 1);
        take = cal && (m_cal == 0);
        @(negedge clk);
        if (take) begin
            m_cal = 1; m_pos = 0; m_run = 0; m_sum = 0; m_cnt = 0;
            check("busy_on_cal", int'(bus.busy), 1);
        end else begin
            m_pos = wend ? 0 : m_pos + 1;
            m_run = wend ? 0 : snap;
            if (wend) begin
                check("peak_at_end", int'(bus.peak), snap);
                check("level_between", int'(bus.level), m_level);
                if (m_cal != 0) begin
                    m_sum += snap;
                    m_cnt++;
                    if (m_cnt == CALW) begin
                        m_base = m_sum >> CSH;
                        m_cal  = 0;
                    end
                end else if (!hold) begin
                    e = (xl >= 0) ? xl : exp_level(snap, m_base);
                    sbq.push_back('{lvl: e, pk: snap});
                    m_level = e;
                end
                check("busy_at_end", int'(bus.busy), m_cal);
                check("base_at_end", int'(bus.base), m_base);
            end
        end
    endtask

    task automatic run_window(input int val, input int xl);
        for (int i = 0; i < W; i++) step(val, 1'b0, 1'b0, (i == W - 1) ? xl : -1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[7];
        int   n;
        vecs[0] = '{mic: 2299, lvl: 0};
        vecs[1] = '{mic: 2374, lvl: 1};
        vecs[2] = '{mic: 2375, lvl: 2};
        vecs[3] = '{mic: 3349, lvl: 14};
        vecs[4] = '{mic: 3350, lvl: 15};
        vecs[5] = '{mic: 4095, lvl: 15};
        vecs[6] = '{mic: 2300, lvl: 1};

        bus.mic_in = '0; bus.cal_req = 1'b0; bus.hold_en = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_level", int'(bus.level), 0);
        check("rst_valid", int'(bus.level_valid), 0);
        check("rst_peak", int'(bus.peak), 0);
        check("rst_base", int'(bus.base), 2300);
        check("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;

        // Constant baseline-level input: one strobe per window, evenly spaced
        for (int i = 0; i < 3; i++) run_window(2300, 1);
        repeat (20) step(2300, 1'b0, 1'b0, -1);
        check("strobe_count", strobes, 3);
        check("strobe_gap", last_strobe - prev_strobe, W);
        while (m_pos != 0) step(2300, 1'b0, 1'b0, 1);

        // Spike only on the last sample of a window, then a quiet window
        for (int i = 0; i < W - 1; i++) step(0, 1'b0, 1'b0, -1);
        step(3350, 1'b0, 1'b0, 15);
        run_window(0, 0);

        for (int v = 0; v < 7; v++) run_window(vecs[v].mic, vecs[v].lvl);

        // Calibration on a constant ambient level
        while (m_pos < 25) step(1000, 1'b0, 1'b0, -1);
        check("drain_before_cal", sbq.size(), 0);
        step(1000, 1'b1, 1'b0, -1);
        while (m_cal != 0) step(1000, 1'b0, 1'b0, -1);
        check("cal_base", int'(bus.base), 1000);
        check("cal_busy_low", int'(bus.busy), 0);
        run_window(1075, 2);

        // cal_req on a window end, then a second request while busy
        while (m_pos != W - 1) step(1500, 1'b0, 1'b0, -1);
        step(1500, 1'b1, 1'b0, -1);
        repeat (10) step(1500, 1'b0, 1'b0, -1);
        step(1500, 1'b1, 1'b0, -1);
        while (m_cal != 0) step(1500, 1'b0, 1'b0, -1);
        check("recal_base", int'(bus.base), 1500);

        // Hold across a window end: no strobe, level keeps its old value
        n = strobes;
        for (int i = 0; i < W; i++) step(3000, 1'b0, 1'b1, -1);
        repeat (20) step(1500, 1'b0, 1'b1, -1);
        check("hold_no_strobe", strobes - n, 0);
        check("hold_level", int'(bus.level), 2);
        while (m_pos != 0) step(1500, 1'b0, 1'b0, 1);

        // Reset in the middle of calibration
        repeat (25) step(1500, 1'b0, 1'b0, -1);
        step(1600, 1'b1, 1'b0, -1);
        repeat (2 * W) step(1600, 1'b0, 1'b0, -1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midcal_rst_base", int'(bus.base), 2300);
        check("midcal_rst_busy", int'(bus.busy), 0);
        check("midcal_rst_level", int'(bus.level), 0);
        check("midcal_rst_peak", int'(bus.peak), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_window(2300, 1);

        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("final_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
